mon_exp_seq: RTL and testbench

MON_EXP_SEQ -- requirements
Module: mon_exp_seq

---
 rtl/mon_exp_pkg.sv | 16 +
 rtl/mp_handshake.sv | 32 +++
 rtl/mon_exp_seq.sv | 203 ++++++++++++++++++++
 tb/tb_mon_exp_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mon_exp_pkg.sv
// rtl/mon_exp_pkg.sv - shared op codes and FSM state encodings for the modular exponentiation sequencer
package mon_exp_pkg;

    localparam logic [1:0] OPXX = 2'd0;
    localparam logic [1:0] OPXM = 2'd1;
    localparam logic [1:0] OPX1 = 2'd2;

    localparam int         ST_W    = 3;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SQR  = 3'd1;
    localparam logic [2:0] ST_MUL  = 3'd2;
    localparam logic [2:0] ST_CONV = 3'd3;
    localparam logic [2:0] ST_ABRT = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

endpackage

// File: rtl/mp_handshake.sv
// rtl/mp_handshake.sv - Montgomery product completion edge detector and outstanding-product tracking
module mp_handshake (
    input  logic clk,
    input  logic rst_n,
    input  logic mp_done,
    input  logic mp_start,
    output logic done_evt,
    output logic pending
);

    logic done_prev;
    logic outstanding;

    // done_prev resets high so a completion line held high through reset is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_prev   <= 1'b1;
            outstanding <= 1'b0;
        end else begin
            done_prev <= mp_done;
            if (mp_start) begin
                outstanding <= 1'b1;
            end else if (done_evt) begin
                outstanding <= 1'b0;
            end
        end
    end

    assign done_evt = mp_done & ~done_prev & outstanding;
    assign pending  = outstanding | mp_start;

endmodule

// File: rtl/mon_exp_seq.sv
// rtl/mon_exp_seq.sv - left-to-right square-and-multiply sequencer; MON_EXP_SEQ_CONST_TIME_EN selects constant-time mode
module mon_exp_seq #(
    parameter int BITLEN     = 256,
    parameter int LOG_BITLEN = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [BITLEN-1:0]       e,
    input  logic [LOG_BITLEN-1:0]   e_idx,
    input  logic                    mp_done,
    output logic                    mp_start,
    output logic [1:0]              op_code,
    output logic                    mp_discard,
    output logic                    busy,
    output logic                    done,
    output logic [LOG_BITLEN+1:0]   op_cnt
);
    import mon_exp_pkg::*;

    localparam logic [LOG_BITLEN+1:0] CNT_ONE = {{(LOG_BITLEN+1){1'b0}}, 1'b1};

    logic [ST_W-1:0]       state;
    logic [ST_W-1:0]       state_n;
    logic [BITLEN-1:0]     e_q;
    logic [LOG_BITLEN-1:0] idx;
    logic [LOG_BITLEN-1:0] idx_n;
    logic                  issue;
    logic [1:0]            issue_op;
    logic                  load;
    logic                  busy_n;
    logic                  done_n;
    logic                  done_evt;
    logic                  pending;
    logic                  cur_bit;
    logic                  idx_zero;
    logic                  take_mul;

    mp_handshake u_hs (
        .clk      (clk),
        .rst_n    (rst_n),
        .mp_done  (mp_done),
        .mp_start (mp_start),
        .done_evt (done_evt),
        .pending  (pending)
    );

    assign cur_bit  = e_q[idx];
    assign idx_zero = (idx == '0);

`ifdef MON_EXP_SEQ_CONST_TIME_EN
    logic disc_q;
    logic disc_n;

    // every bit runs the multiply; zero bits mark its result as not committed
    assign take_mul   = 1'b1;
    assign mp_discard = disc_q;
`else
    assign take_mul   = cur_bit;
    assign mp_discard = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        issue    = 1'b0;
        issue_op = op_code;
        load     = 1'b0;
        busy_n   = busy;
        done_n   = 1'b0;
`ifdef MON_EXP_SEQ_CONST_TIME_EN
        disc_n   = disc_q;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    idx_n    = e_idx;
                    busy_n   = 1'b1;
                    issue    = 1'b1;
                    issue_op = OPXX;
                    state_n  = ST_SQR;
`ifdef MON_EXP_SEQ_CONST_TIME_EN
                    disc_n   = 1'b0;
`endif
                end
            end
            ST_SQR: begin
                if (done_evt) begin
                    issue = 1'b1;
                    if (take_mul) begin
                        issue_op = OPXM;
                        state_n  = ST_MUL;
`ifdef MON_EXP_SEQ_CONST_TIME_EN
                        disc_n   = ~cur_bit;
`endif
                    end else if (idx_zero) begin
                        issue_op = OPX1;
                        state_n  = ST_CONV;
                    end else begin
                        idx_n    = idx - 1'b1;
                        issue_op = OPXX;
                    end
                end
            end
            ST_MUL: begin
                if (done_evt) begin
                    issue = 1'b1;
`ifdef MON_EXP_SEQ_CONST_TIME_EN
                    disc_n = 1'b0;
`endif
                    if (idx_zero) begin
                        issue_op = OPX1;
                        state_n  = ST_CONV;
                    end else begin
                        idx_n    = idx - 1'b1;
                        issue_op = OPXX;
                        state_n  = ST_SQR;
                    end
                end
            end
            ST_CONV: begin
                if (done_evt) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_FIN;
                end
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            ST_ABRT: begin
                if (done_evt) begin
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
`ifdef MON_EXP_SEQ_CONST_TIME_EN
                    disc_n  = 1'b0;
`endif
                end
            end
            default: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

        // abort overrides any issue decided above, including one triggered by a same-cycle completion
        if (abort && (state != ST_IDLE) && (state != ST_ABRT)) begin
            issue    = 1'b0;
            issue_op = op_code;
            done_n   = 1'b0;
            idx_n    = idx;
            if (pending && !done_evt) begin
                busy_n  = 1'b1;
                state_n = ST_ABRT;
            end else begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
`ifdef MON_EXP_SEQ_CONST_TIME_EN
                disc_n  = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            e_q      <= '0;
            idx      <= '0;
            mp_start <= 1'b0;
            op_code  <= OPXX;
            busy     <= 1'b0;
            done     <= 1'b0;
            op_cnt   <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            mp_start <= issue;
            op_code  <= issue_op;
            busy     <= busy_n;
            done     <= done_n;
            if (load) begin
                e_q    <= e;
                op_cnt <= CNT_ONE;
            end else if (issue) begin
                op_cnt <= op_cnt + CNT_ONE;
            end
        end
    end

`ifdef MON_EXP_SEQ_CONST_TIME_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disc_q <= 1'b0;
        end else begin
            disc_q <= disc_n;
        end
    end
`endif

endmodule

// File: tb/tb_mon_exp_seq.sv
// tb/tb_mon_exp_seq.sv - scoreboard bench for mon_exp_seq with a fixed-latency mock multiplier
module tb_mon_exp_seq;
    import mon_exp_pkg::*;

    localparam int BL = 256;
    localparam int LB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [BL-1:0] e;
    logic [LB-1:0] e_idx;
    logic          mp_done;
    logic          mp_start;
    logic [1:0]    op_code;
    logic          mp_discard;
    logic          busy;
    logic          done;
    logic [LB+1:0] op_cnt;

    mon_exp_seq #(.BITLEN(BL), .LOG_BITLEN(LB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .e          (e),
        .e_idx      (e_idx),
        .mp_done    (mp_done),
        .mp_start   (mp_start),
        .op_code    (op_code),
        .mp_discard (mp_discard),
        .busy       (busy),
        .done       (done),
        .op_cnt     (op_cnt)
    );

    always #5 clk = ~clk;

    // mock multiplier: completion pulse 4 cycles after each request
    logic [3:0] sr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[2:0], mp_start};
    end
    assign mp_done = sr[3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]    exp_ops[$];
    logic [LB+1:0] exp_done[$];
    int checks = 0;
    int errors = 0;
    int n_starts = 0;
    int n_dones = 0;
    int last_done_cyc = -10;
    int last_start_cyc = -10;
    int start_cyc = -10;
    bit prev_md = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // S=square, M=multiply, D=multiply with discard, 1=final multiply by one
    task automatic push_str(input string s, input logic [LB+1:0] cnt);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "S": exp_ops.push_back({1'b0, OPXX});
                "M": exp_ops.push_back({1'b0, OPXM});
                "D": exp_ops.push_back({1'b1, OPXM});
                default: exp_ops.push_back({1'b0, OPX1});
            endcase
        end
        exp_done.push_back(cnt);
    endtask

    // monitor
    initial begin
        logic [2:0] eo;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mp_done && !prev_md) last_done_cyc = cyc;
                prev_md = mp_done;
                if (mp_start) begin
                    n_starts++;
                    last_start_cyc = cyc;
                    if (exp_ops.size() == 0) begin
                        fail_now("unexpected_mp_start");
                    end else begin
                        eo = exp_ops.pop_front();
                        chk("op_code", op_code, eo[1:0]);
                        chk("mp_discard", mp_discard, eo[2]);
                        chk("mp_start_timing", (cyc == last_done_cyc + 1) || (cyc == start_cyc + 1), 1);
                    end
                end
                if (done) begin
                    n_dones++;
                    if (exp_done.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        chk("done_op_cnt", op_cnt, exp_done.pop_front());
                    end
                    chk("done_busy_low", busy, 0);
                    chk("done_timing", cyc == last_done_cyc + 1, 1);
                end
            end else begin
                prev_md = 1'b1;
            end
        end
    end

    task automatic start_run(input logic [BL-1:0] ev, input logic [LB-1:0] ix);
        @(negedge clk);
        e = ev;
        e_idx = ix;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_dones < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_dones < target) fail_now("timeout_waiting_done");
    endtask

    task automatic wait_starts(input int target, input int budget);
        int k = 0;
        while (n_starts < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_starts < target) fail_now("timeout_waiting_mp_start");
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mp_start"}, mp_start, 0);
        chk({tag, "_op_code"}, op_code, 0);
        chk({tag, "_mp_discard"}, mp_discard, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_op_cnt"}, op_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int s2;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        e = '0;
        e_idx = '0;
        #23;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // e=1011, e_idx=3
`ifdef MON_EXP_SEQ_CONST_TIME_EN
        push_str("SMSDSMSM1", 9);
`else
        push_str("SMSSMSM1", 8);
`endif
        start_run(256'hB, 8'd3);
        wait_done(1, 300);
        repeat (3) @(negedge clk);
`ifdef MON_EXP_SEQ_CONST_TIME_EN
        chk("op_cnt_hold", op_cnt, 9);
`else
        chk("op_cnt_hold", op_cnt, 8);
`endif
        chk("idle_busy", busy, 0);

        // e=0, e_idx=0
`ifdef MON_EXP_SEQ_CONST_TIME_EN
        push_str("SD1", 3);
`else
        push_str("S1", 2);
`endif
        start_run(256'h0, 8'd0);
        wait_done(2, 100);

        // e bits above e_idx must be ignored; start mid-run must be ignored
`ifdef MON_EXP_SEQ_CONST_TIME_EN
        push_str("SMSDSMSDSDSMSDSM1", 17);
`else
        push_str("SMSSMSSSMSSM1", 13);
`endif
        base = n_starts;
        start_run(256'hFFA5, 8'd7);
        wait_starts(base + 3, 100);
        @(negedge clk);
        chk("busy_mid_run", busy, 1);
        e = 256'h0;
        e_idx = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, 600);

        // abort two cycles into the second product
        exp_ops.push_back({1'b0, OPXX});
        exp_ops.push_back({1'b0, OPXM});
        base = n_starts;
        start_run(256'hB, 8'd3);
        wait_starts(base + 2, 100);
        s2 = last_start_cyc;
        wait_cyc(s2 + 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_cyc(s2 + 3);
        chk("abort_busy_held", busy, 1);
        wait_cyc(s2 + 5);
        chk("abort_busy_dropped", busy, 0);
        chk("abort_op_cnt", op_cnt, 2);
        repeat (10) @(negedge clk);
        chk("abort_no_done", n_dones, 3);
        chk("abort_no_new_start", n_starts, base + 2);

        // reset mid-run
`ifdef MON_EXP_SEQ_CONST_TIME_EN
        push_str("SMSDSMSM1", 9);
`else
        push_str("SMSSMSM1", 8);
`endif
        base = n_starts;
        start_run(256'hB, 8'd3);
        wait_starts(base + 3, 100);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_ops.delete();
        exp_done.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef MON_EXP_SEQ_CONST_TIME_EN
        push_str("SD1", 3);
`else
        push_str("S1", 2);
`endif
        start_run(256'h0, 8'd0);
        wait_done(4, 100);
        repeat (3) @(negedge clk);

        chk("ops_drained", exp_ops.size(), 0);
        chk("dones_drained", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
